// File: rtl/alu_seq_pkg.sv
// Shared opcode, ALU select and state encodings for the accumulator ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEL_W  = 3;

  localparam logic [OP_W-1:0] OP_AND = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_LDA = 4'd2;
  localparam logic [OP_W-1:0] OP_STA = 4'd3;
  localparam logic [OP_W-1:0] OP_CMA = 4'd4;
  localparam logic [OP_W-1:0] OP_CIR = 4'd5;
  localparam logic [OP_W-1:0] OP_CIL = 4'd6;
  localparam logic [OP_W-1:0] OP_CLA = 4'd7;
  localparam logic [OP_W-1:0] OP_CLE = 4'd8;
  localparam logic [OP_W-1:0] OP_CME = 4'd9;

  localparam logic [SEL_W-1:0] SEL_AND = 3'b000;
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b001;
  localparam logic [SEL_W-1:0] SEL_DR  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_CMA = 3'b011;
  localparam logic [SEL_W-1:0] SEL_SHR = 3'b100;
  localparam logic [SEL_W-1:0] SEL_SHL = 3'b101;
  localparam logic [SEL_W-1:0] SEL_NOP = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_EXEC,
    ST_ROT,
    ST_FIN
  } state_t;

  // ALU select used while executing a single-cycle op; register-only ops park the ALU
  function automatic logic [SEL_W-1:0] exec_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_AND:  exec_sel = SEL_AND;
      OP_ADD:  exec_sel = SEL_ADD;
      OP_LDA:  exec_sel = SEL_DR;
      OP_CMA:  exec_sel = SEL_CMA;
      default: exec_sel = SEL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_mem_port.sv
// Memory request port: holds req/we/addr/wdata stable until ack and times out a silent memory.
module alu_mem_port
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_next,
  input  logic              i_we_next,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_ack_c,
  output logic              o_timeout_c
);

  localparam int unsigned CNT_W = 8;

  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_last;

  assign w_last      = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign o_ack_c     = r_req & i_mem_ack;
  assign o_timeout_c = r_req & ~i_mem_ack & w_last;

  // Address and write data are captured on the launch edge, which is the start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_req <= i_req_next;
      r_we  <= i_req_next & i_we_next;
      if (i_req_next && !r_req) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      r_cnt <= (r_req && !i_mem_ack && !w_last) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller owning AC/DR/E: fetches/stores operands, drives the ALU select, writes back results.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        shamt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        aselect,
  output logic [15:0]       ac_q,
  output logic [15:0]       dr_q,
  output logic              e_q,
  input  logic [16:0]       alu_out,
  input  logic              alu_co,
  input  logic              alu_ovf,
  input  logic              alu_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              ovf_q,
  output logic              n_q,
  output logic              z_q
);

  state_t             r_state, w_state_n;
  logic [OP_W-1:0]    r_op, w_op_n;
  logic [3:0]         r_rot, w_rot_n;
  logic [DATA_W-1:0]  r_ac, w_ac_n, r_dr, w_dr_n;
  logic               r_e, w_e_n;
  logic               r_ovf, w_ovf_n, r_n, w_n_n, r_z, w_z_n;
  logic               r_done, w_done_n, r_err, w_err_n, r_busy;
  logic [SEL_W-1:0]   r_sel, w_sel_n;
  logic               w_req_n, w_we_n, w_ack, w_timeout;

  alu_mem_port #(
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_mem_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_next  (w_req_n),
    .i_we_next   (w_we_n),
    .i_addr      (addr),
    .i_wdata     (r_ac),
    .i_mem_ack   (mem_ack),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_ack_c     (w_ack),
    .o_timeout_c (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_op_n    = r_op;
    w_rot_n   = r_rot;
    w_ac_n    = r_ac;
    w_dr_n    = r_dr;
    w_e_n     = r_e;
    w_ovf_n   = r_ovf;
    w_n_n     = r_n;
    w_z_n     = r_z;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_sel_n   = SEL_NOP;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_op_n  = op;
          w_rot_n = shamt;
          w_ovf_n = 1'b0;
          w_n_n   = 1'b0;
          w_z_n   = 1'b0;
          case (op)
            OP_AND, OP_ADD, OP_LDA:         w_state_n = ST_MEM_RD;
            OP_STA:                         w_state_n = ST_MEM_WR;
            OP_CMA, OP_CLA, OP_CLE, OP_CME: w_state_n = ST_EXEC;
            OP_CIR, OP_CIL:                 w_state_n = (shamt == 4'd0) ? ST_FIN : ST_ROT;
            default:                        w_err_n   = 1'b1;
          endcase
        end
      end
      ST_MEM_RD: begin
        if (w_ack) begin
          w_dr_n    = mem_rdata;
          w_state_n = ST_EXEC;
        end else if (w_timeout) begin
          w_err_n   = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      ST_MEM_WR: begin
        if (w_ack) begin
          w_state_n = ST_FIN;
        end else if (w_timeout) begin
          w_err_n   = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (r_op)
          OP_AND, OP_LDA, OP_CMA: begin
            w_ac_n = alu_out[15:0];
            w_n_n  = alu_n;
          end
          OP_ADD: begin
            w_ac_n  = alu_out[15:0];
            w_e_n   = alu_co;
            w_ovf_n = alu_ovf;
            w_n_n   = alu_n;
          end
          OP_CLA: begin
            w_ac_n = '0;
            w_n_n  = 1'b0;
          end
          OP_CLE:  w_e_n = 1'b0;
          OP_CME:  w_e_n = ~r_e;
          default: w_e_n = r_e;
        endcase
        w_state_n = ST_FIN;
      end
      ST_ROT: begin
        w_ac_n  = alu_out[15:0];
        w_e_n   = alu_out[16];
        w_rot_n = r_rot - 4'd1;
        if (r_rot == 4'd1) w_state_n = ST_FIN;
      end
      ST_FIN: begin
        // Status reflects AC after writeback; the ALU's own zero flag is not trusted here
        w_done_n  = 1'b1;
        w_z_n     = (r_ac == '0);
        w_n_n     = r_ac[15];
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase

    w_req_n = (w_state_n == ST_MEM_RD) || (w_state_n == ST_MEM_WR);
    w_we_n  = (w_state_n == ST_MEM_WR);
    if (w_state_n == ST_EXEC)     w_sel_n = exec_sel(w_op_n);
    else if (w_state_n == ST_ROT) w_sel_n = (w_op_n == OP_CIR) ? SEL_SHR : SEL_SHL;
  end

  // Datapath and registered outputs; aselect is set up one edge ahead so it is valid in EXEC/ROT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_rot  <= '0;
      r_ac   <= '0;
      r_dr   <= '0;
      r_e    <= 1'b0;
      r_ovf  <= 1'b0;
      r_n    <= 1'b0;
      r_z    <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
      r_sel  <= SEL_NOP;
    end else begin
      r_op   <= w_op_n;
      r_rot  <= w_rot_n;
      r_ac   <= w_ac_n;
      r_dr   <= w_dr_n;
      r_e    <= w_e_n;
      r_ovf  <= w_ovf_n;
      r_n    <= w_n_n;
      r_z    <= w_z_n;
      r_done <= w_done_n;
      r_err  <= w_err_n;
      r_busy <= (w_state_n != ST_IDLE);
      r_sel  <= w_sel_n;
    end
  end

  assign aselect = r_sel;
  assign ac_q    = r_ac;
  assign dr_q    = r_dr;
  assign e_q     = r_e;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_err;
  assign ovf_q   = r_ovf;
  assign n_q     = r_n;
  assign z_q     = r_z;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU and an in-task memory responder.
module tb_alu_op_sequencer;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned ACK_TIMEOUT = 15;

  logic              clk, rst_n, start;
  logic [3:0]        op, shamt;
  logic [ADDR_W-1:0] addr;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata, mem_rdata;
  logic [2:0]        aselect;
  logic [15:0]       ac_q, dr_q;
  logic              e_q;
  logic [16:0]       alu_out, alu_sum;
  logic              alu_co, alu_ovf, alu_n;
  logic              busy, done, error, ovf_q, n_q, z_q;

  typedef struct packed {
    logic [15:0] ac;
    logic        e;
    logic        ovf;
    logic        n;
    logic        z;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_ac;
  logic        m_e;

  int          g_req_cyc, g_lat;
  logic        g_done, g_err, g_we, g_stable, g_busy;
  logic [11:0] g_addr;
  logic [15:0] g_wdata;
  exp_t        g_obs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator ALU living beside the sequencer
  always_comb begin
    alu_co  = 1'b0;
    alu_ovf = 1'b0;
    alu_sum = {1'b0, ac_q} + {1'b0, dr_q};
    case (aselect)
      3'b000: alu_out = {1'b0, ac_q & dr_q};
      3'b001: begin
        alu_out = alu_sum;
        alu_co  = alu_sum[16];
        alu_ovf = (ac_q[15] == dr_q[15]) && (alu_sum[15] != ac_q[15]);
      end
      3'b010: alu_out = {1'b0, dr_q};
      3'b011: alu_out = {1'b0, ~ac_q};
      3'b100: alu_out = {ac_q[0], e_q, ac_q[15:1]};
      3'b101: alu_out = {ac_q[15], ac_q[14:0], e_q};
      default: alu_out = {e_q, ac_q};
    endcase
    alu_n = alu_out[15];
  end

  alu_op_sequencer #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .shamt(shamt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .aselect(aselect),
    .ac_q(ac_q), .dr_q(dr_q), .e_q(e_q),
    .alu_out(alu_out), .alu_co(alu_co), .alu_ovf(alu_ovf), .alu_n(alu_n),
    .busy(busy), .done(done), .error(error), .ovf_q(ovf_q), .n_q(n_q), .z_q(z_q)
  );

  // Reference model: applies one op to m_ac/m_e and queues the expected final state
  task automatic model_push(input logic [3:0] o, input logic [15:0] d, input logic [3:0] sh);
    logic [16:0] s;
    logic        v;
    v = 1'b0;
    case (o)
      4'd0: m_ac = m_ac & d;
      4'd1: begin
        s    = {1'b0, m_ac} + {1'b0, d};
        v    = (m_ac[15] == d[15]) && (s[15] != m_ac[15]);
        m_ac = s[15:0];
        m_e  = s[16];
      end
      4'd2: m_ac = d;
      4'd4: m_ac = ~m_ac;
      4'd5: for (int i = 0; i < int'(sh); i++) {m_e, m_ac} = {m_ac[0], m_e, m_ac[15:1]};
      4'd6: for (int i = 0; i < int'(sh); i++) {m_e, m_ac} = {m_ac[15], m_ac[14:0], m_e};
      4'd7: m_ac = 16'h0000;
      4'd8: m_e = 1'b0;
      4'd9: m_e = ~m_e;
      default: ;
    endcase
    sb_q.push_back({m_ac, m_e, v, m_ac[15], (m_ac == 16'h0000)});
  endtask

  // Launch one op, answer the memory port after ack_after request cycles (0 = never), wait for done/error
  task automatic issue(input logic [3:0] i_op, input logic [11:0] i_addr, input logic [3:0] i_sh,
                       input logic [15:0] i_rd, input int ack_after);
    g_req_cyc = 0; g_lat = 0; g_done = 0; g_err = 0; g_we = 0; g_stable = 1;
    g_addr = '0; g_wdata = '0; g_busy = 0; g_obs = '0;
    @(negedge clk);
    start = 1'b1; op = i_op; addr = i_addr; shamt = i_sh;
    @(negedge clk);
    start = 1'b0; op = 4'hE; addr = ~i_addr; shamt = 4'h0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      g_lat     = c;
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      if (mem_req) begin
        g_req_cyc++;
        if (g_req_cyc == 1) begin
          g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
        end else if (mem_we !== g_we || mem_addr !== g_addr || mem_wdata !== g_wdata) begin
          g_stable = 0;
        end
        if (g_req_cyc == ack_after) begin
          mem_ack   = 1'b1;
          mem_rdata = i_rd;
        end
      end
      if (done || error) begin
        g_done = done; g_err = error; g_busy = busy;
        g_obs  = {ac_q, e_q, ovf_q, n_q, z_q};
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, busy, done, error, ovf_q, n_q, z_q, e_q} !== 9'b0 ||
        ac_q !== 16'h0 || dr_q !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: req=%b we=%b busy=%b done=%b err=%b ac=%h dr=%h e=%b want all 0",
               mem_req, mem_we, busy, done, error, ac_q, dr_q, e_q);
    end
    n_tests++;
    if (aselect !== 3'b110) begin
      n_fail++; $display("FAIL reset_aselect: got %b want 110", aselect);
    end
    rst_n = 1'b1;
    m_ac = 16'h0; m_e = 1'b0;
  endtask

  task automatic test_lda();
    exp_t x;
    model_push(4'd2, 16'h1234, 4'd0);
    issue(4'd2, 12'h010, 4'd0, 16'h1234, 3);
    x = sb_q.pop_front();
    n_tests++;
    if (g_done !== 1'b1 || g_err !== 1'b0 || g_obs !== x) begin
      n_fail++; $display("FAIL lda_result: done=%b err=%b got %h want %h", g_done, g_err, g_obs, x);
    end
    n_tests++;
    if (g_req_cyc != 3 || g_we !== 1'b0 || g_addr !== 12'h010 || !g_stable) begin
      n_fail++; $display("FAIL lda_port: req_cycles=%0d we=%b addr=%h stable=%b want 3/0/010/1",
                         g_req_cyc, g_we, g_addr, g_stable);
    end
    n_tests++;
    if (dr_q !== 16'h1234) begin
      n_fail++; $display("FAIL lda_dr: got %h want 1234", dr_q);
    end
  endtask

  task automatic test_add();
    exp_t x;
    logic [15:0] vals [3] = '{16'h7FFF, 16'h0001, 16'h8000};
    logic [3:0]  ops  [3] = '{4'd2, 4'd1, 4'd1};
    for (int k = 0; k < 3; k++) begin
      model_push(ops[k], vals[k], 4'd0);
      issue(ops[k], 12'h020, 4'd0, vals[k], k + 1);
      x = sb_q.pop_front();
      n_tests++;
      if (g_done !== 1'b1 || g_obs !== x) begin
        n_fail++; $display("FAIL add_step%0d: done=%b got %h want %h", k, g_done, g_obs, x);
      end
    end
  endtask

  task automatic test_rotate();
    exp_t x;
    logic [3:0]  ops [4] = '{4'd2, 4'd8, 4'd5, 4'd6};
    logic [3:0]  shs [4] = '{4'd0, 4'd0, 4'd1, 4'd3};
    for (int k = 0; k < 4; k++) begin
      model_push(ops[k], 16'h0001, shs[k]);
      issue(ops[k], 12'h030, shs[k], 16'h0001, 1);
      x = sb_q.pop_front();
      n_tests++;
      if (g_done !== 1'b1 || g_obs !== x) begin
        n_fail++; $display("FAIL rot_step%0d: done=%b got %h want %h", k, g_done, g_obs, x);
      end
      if (k >= 2) begin
        n_tests++;
        if (g_lat != int'(shs[k]) + 2) begin
          n_fail++; $display("FAIL rot_latency%0d: got %0d want %0d", k, g_lat, int'(shs[k]) + 2);
        end
      end
    end
    model_push(4'd5, 16'h0, 4'd0);
    issue(4'd5, 12'h0, 4'd0, 16'h0, 1);
    x = sb_q.pop_front();
    n_tests++;
    if (g_done !== 1'b1 || g_obs !== x || g_lat != 2) begin
      n_fail++; $display("FAIL rot_zero: done=%b lat=%0d got %h want %h lat 2", g_done, g_lat, g_obs, x);
    end
  endtask

  task automatic test_sta();
    exp_t x;
    model_push(4'd2, 16'h5A5A, 4'd0);
    issue(4'd2, 12'h040, 4'd0, 16'h5A5A, 1);
    void'(sb_q.pop_front());
    model_push(4'd3, 16'h0, 4'd0);
    issue(4'd3, 12'hABC, 4'd0, 16'h0, 2);
    x = sb_q.pop_front();
    n_tests++;
    if (g_done !== 1'b1 || g_obs !== x) begin
      n_fail++; $display("FAIL sta_result: done=%b got %h want %h", g_done, g_obs, x);
    end
    n_tests++;
    if (g_we !== 1'b1 || g_addr !== 12'hABC || g_wdata !== 16'h5A5A || !g_stable || g_req_cyc != 2) begin
      n_fail++; $display("FAIL sta_port: we=%b addr=%h wdata=%h stable=%b req=%0d want 1/abc/5a5a/1/2",
                         g_we, g_addr, g_wdata, g_stable, g_req_cyc);
    end
  endtask

  task automatic test_reg_ops();
    exp_t x;
    logic [3:0]  ops [6] = '{4'd4, 4'd0, 4'd9, 4'd9, 4'd7, 4'd4};
    logic [15:0] ds  [6] = '{16'h0, 16'h0FF0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int k = 0; k < 6; k++) begin
      model_push(ops[k], ds[k], 4'd0);
      issue(ops[k], 12'h050, 4'd0, ds[k], 1);
      x = sb_q.pop_front();
      n_tests++;
      if (g_done !== 1'b1 || g_obs !== x) begin
        n_fail++; $display("FAIL regop%0d op=%0d: done=%b got %h want %h", k, ops[k], g_done, g_obs, x);
      end
    end
  endtask

  task automatic test_errors();
    issue(4'hF, 12'h060, 4'd0, 16'h0, 1);
    n_tests++;
    if (g_err !== 1'b1 || g_done !== 1'b0 || g_req_cyc != 0 || g_lat != 1) begin
      n_fail++; $display("FAIL illegal_op: err=%b done=%b req=%0d lat=%0d want 1/0/0/1",
                         g_err, g_done, g_req_cyc, g_lat);
    end
    issue(4'd1, 12'h070, 4'd0, 16'h1111, 0);
    n_tests++;
    if (g_err !== 1'b1 || g_done !== 1'b0 || g_req_cyc != int'(ACK_TIMEOUT) || g_busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout: err=%b done=%b req=%0d busy=%b want 1/0/%0d/0",
                         g_err, g_done, g_req_cyc, g_busy, ACK_TIMEOUT);
    end
    n_tests++;
    if (ac_q !== m_ac || e_q !== m_e || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_regs: ac=%h e=%b req=%b want %h/%b/0", ac_q, e_q, mem_req, m_ac, m_e);
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    @(negedge clk);
    start = 1'b1; op = 4'd2; addr = 12'h080;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: req=%b busy=%b want 1/1", mem_req, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || ac_q !== 16'h0 || dr_q !== 16'h0 || e_q !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: req=%b busy=%b ac=%h dr=%h e=%b want all 0",
                         mem_req, busy, ac_q, dr_q, e_q);
    end
    m_ac = 16'h0; m_e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_push(4'd2, 16'hBEEF, 4'd0);
    issue(4'd2, 12'h090, 4'd0, 16'hBEEF, 1);
    x = sb_q.pop_front();
    n_tests++;
    if (g_done !== 1'b1 || g_obs !== x || g_req_cyc != 1) begin
      n_fail++; $display("FAIL post_reset_lda: done=%b req=%0d got %h want %h", g_done, g_req_cyc, g_obs, x);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'h0; addr = '0; shamt = 4'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    m_ac = 16'h0; m_e = 1'b0;
    test_reset();
    test_lda();
    test_add();
    test_rotate();
    test_sta();
    test_reg_ops();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
